reset_seq: RTL and testbench

Parametrised reset sequencer for the board top level. It holds a configurable number of active-low reset outputs low after any reset cause, then releases them one by one in index order with a fixed gap between each. Reset causes are power-on/async rst, a debounced push-button, and a synchronous software request from the SoC. It also reports the last cause and counts warm resets.

---
 rtl/reset_seq.sv | 180 ++++++++++++++++++
 tb/tb_reset_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/reset_seq.sv
// Staged reset sequencer. It holds N_STAGES active-low resets low after any reset cause
// (rst, debounced button or soft_req), then releases them in index order.
module reset_seq #(
  parameter int HOLD_CYCLES     = 8,
  parameter int N_STAGES        = 2,
  parameter int STAGE_GAP       = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_n,
  input  logic                soft_req,
  output logic [N_STAGES-1:0] resetn,
  output logic                busy,
  output logic [1:0]          rst_cause,
  output logic [7:0]          rst_count
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_SAT    = DW'(DEBOUNCE_CYCLES);

  localparam logic [1:0] CAUSE_RST  = 2'd0;
  localparam logic [1:0] CAUSE_BTN  = 2'd1;
  localparam logic [1:0] CAUSE_SOFT = 2'd2;

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_seq: HOLD_CYCLES must be >= 1");
  end
  if (N_STAGES < 1) begin : g_bad_stages
    $error("reset_seq: N_STAGES must be >= 1");
  end
  if (STAGE_GAP < 1) begin : g_bad_gap
    $error("reset_seq: STAGE_GAP must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("reset_seq: DEBOUNCE_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t              r_state;
  logic [HW-1:0]       r_hold_cnt;
  logic [GW-1:0]       r_gap_cnt;
  logic [N_STAGES-1:0] r_resetn;
  logic                r_busy;
  logic [1:0]          r_cause;
  logic [7:0]          r_count;
  logic                r_sync1;
  logic                r_sync2;
  logic [DW-1:0]       r_db_cnt;
  logic                r_latch;

  state_t              w_state_nxt;
  logic [HW-1:0]       w_hold_nxt;
  logic [GW-1:0]       w_gap_nxt;
  logic [N_STAGES-1:0] w_resetn_nxt;
  logic [1:0]          w_cause_nxt;
  logic [7:0]          w_count_nxt;
  logic [DW-1:0]       w_db_nxt;
  logic                w_latch_nxt;
  logic                w_pressed;
  logic                w_btn_evt;
  logic                w_trig;
  logic                w_hold_en;

  // A press event fires once per press; the latch blocks refiring until release.
  assign w_pressed = ~r_sync2;
  assign w_btn_evt = w_pressed & ~r_latch & (r_db_cnt == DB_LAST);
  assign w_trig    = w_btn_evt | soft_req;
  assign w_hold_en = ~(r_latch & w_pressed);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch can infer.
    w_db_nxt    = r_db_cnt;
    w_latch_nxt = r_latch;
    if (!w_pressed) begin
      w_db_nxt    = '0;
      w_latch_nxt = 1'b0;
    end else begin
      if (r_db_cnt != DB_SAT) w_db_nxt = r_db_cnt + 1'b1;
      if (w_btn_evt)          w_latch_nxt = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold_cnt;
    w_gap_nxt    = r_gap_cnt;
    w_resetn_nxt = r_resetn;
    w_cause_nxt  = r_cause;
    w_count_nxt  = r_count;

    unique case (r_state)
      S_HOLD: begin
        w_resetn_nxt = '0;
        if (!w_hold_en) begin
          w_hold_nxt = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_hold_nxt      = '0;
          w_gap_nxt       = '0;
          w_resetn_nxt[0] = 1'b1;
          w_state_nxt     = (N_STAGES == 1) ? S_RUN : S_RELEASE;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        if (r_gap_cnt == GAP_LAST) begin
          // Releases happen in index order, so the next bit shifts in as a thermometer.
          w_gap_nxt    = '0;
          w_resetn_nxt = N_STAGES'({r_resetn, 1'b1});
          if (&w_resetn_nxt) w_state_nxt = S_RUN;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      S_RUN: ;
      default: begin
        w_state_nxt  = S_HOLD;
        w_hold_nxt   = '0;
        w_resetn_nxt = '0;
      end
    endcase

    // A trigger in any state restarts the whole sequence; the button wins a tie.
    if (w_trig) begin
      w_state_nxt  = S_HOLD;
      w_hold_nxt   = '0;
      w_gap_nxt    = '0;
      w_resetn_nxt = '0;
      w_cause_nxt  = w_btn_evt ? CAUSE_BTN : CAUSE_SOFT;
      if (r_count != 8'hFF) w_count_nxt = r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_HOLD;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_resetn   <= '0;
      r_busy     <= 1'b1;
      r_cause    <= CAUSE_RST;
      r_count    <= '0;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_db_cnt   <= '0;
      r_latch    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_resetn   <= w_resetn_nxt;
      r_busy     <= ~&w_resetn_nxt;
      r_cause    <= w_cause_nxt;
      r_count    <= w_count_nxt;
      r_sync1    <= btn_n;
      r_sync2    <= r_sync1;
      r_db_cnt   <= w_db_nxt;
      r_latch    <= w_latch_nxt;
    end
  end

  assign resetn    = r_resetn;
  assign busy      = r_busy;
  assign rst_cause = r_cause;
  assign rst_count = r_count;

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq. A timestamp-based model predicts outputs after each edge,
// and a negedge monitor pops and compares them.
module tb_reset_seq;

  localparam int HOLD = 8;
  localparam int NS   = 2;
  localparam int GAP  = 4;
  localparam int DB   = 16;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          btn_n    = 1'b1;
  logic          soft_req = 1'b0;
  logic [NS-1:0] resetn;
  logic          busy;
  logic [1:0]    rst_cause;
  logic [7:0]    rst_count;

  reset_seq #(
    .HOLD_CYCLES(HOLD), .N_STAGES(NS), .STAGE_GAP(GAP), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .soft_req(soft_req),
    .resetn(resetn), .busy(busy), .rst_cause(rst_cause), .rst_count(rst_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS-1:0] resetn;
    logic          busy;
    logic [1:0]    cause;
    logic [7:0]    count;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   running  = 1'b0;

  // Model: m_start is the first edge counted toward HOLD; stage k is released on
  // edge m_start + HOLD-1 + k*GAP. The btn samples are delayed two edges.
  int       m_edge;
  int       m_start;
  int       m_run;
  int       m_count;
  bit       m_s1;
  bit       m_s2;
  bit       m_latch;
  bit [1:0] m_cause;

  task automatic m_reset();
    m_edge  = 0;
    m_start = 1;
    m_run   = 0;
    m_count = 0;
    m_s1    = 1'b1;
    m_s2    = 1'b1;
    m_latch = 1'b0;
    m_cause = 2'd0;
  endtask

  task automatic m_step(input bit b, input bit s);
    bit pressed;
    bit evt;
    m_edge++;
    pressed = !m_s2;
    m_s2    = m_s1;
    m_s1    = b;
    m_run   = pressed ? m_run + 1 : 0;
    evt     = pressed && !m_latch && (m_run == DB);
    if (m_latch && !pressed) m_latch = 1'b0;
    if (evt || s) begin
      m_cause = evt ? 2'd1 : 2'd2;
      if (m_count < 255) m_count++;
      m_start = m_edge + 1;
    end
    if (evt) m_latch = 1'b1;
    if (m_latch) m_start = m_edge + 1;
  endtask

  function automatic obs_t m_outputs();
    obs_t o;
    for (int k = 0; k < NS; k++) o.resetn[k] = (m_edge >= m_start + HOLD - 1 + k * GAP);
    o.busy  = !(&o.resetn);
    o.cause = m_cause;
    o.count = 8'(m_count);
    return o;
  endfunction

  always @(negedge clk) begin
    if (running) begin
      obs_t e;
      obs_t a;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL queue_underflow t=%0t got no expected entry, required one", $time);
      end else begin
        e = exp_q.pop_front();
        a = {resetn, busy, rst_cause, rst_count};
        if (a !== e) begin
          n_fail++;
          if (n_fail <= 30)
            $display("FAIL outputs t=%0t got resetn=%b busy=%b cause=%0d count=%0d, required resetn=%b busy=%b cause=%0d count=%0d",
                     $time, a.resetn, a.busy, a.cause, a.count, e.resetn, e.busy, e.cause, e.count);
        end
      end
    end
  end

  // One clock cycle: drive inputs, predict, optionally pulse rst between edges.
  task automatic cycle(input bit b, input bit s, input bit rst_mid);
    btn_n    = b;
    soft_req = s;
    m_step(b, s);
    if (rst_mid) m_reset();
    exp_q.push_back(m_outputs());
    @(posedge clk);
    if (rst_mid) begin
      #2;
      rst = 1'b1;
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int press_left;
    bit b;
    m_reset();
    exp_q.push_back(m_outputs());
    running = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Power-on sequence.
    idle(20);

    // Short press ignored, long press held then released.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
    idle(20);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 1'b0);
    idle(30);

    // soft_req shortly after resetn[0] rises restarts the sequence.
    cycle(1'b1, 1'b1, 1'b0);
    idle(10);
    cycle(1'b1, 1'b1, 1'b0);
    idle(20);

    // Repeated soft requests drive rst_count into saturation.
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      idle($urandom_range(1, 14));
    end
    idle(15);

    // rst pulsed mid-RELEASE between clock edges.
    cycle(1'b1, 1'b1, 1'b0);
    idle(9);
    cycle(1'b1, 1'b0, 1'b1);
    idle(20);

    // Button event and soft_req on the same edge.
    for (int i = 0; i < 30; i++) cycle(1'b0, (i == 17), 1'b0);
    idle(30);

    // Random traffic.
    press_left = 0;
    for (int i = 0; i < 2000; i++) begin
      if (press_left > 0) begin
        b = 1'b0;
        press_left--;
      end else begin
        b = 1'b1;
        if ($urandom_range(0, 49) == 0) press_left = $urandom_range(3, 40);
      end
      cycle(b, ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0));
    end
    idle(20);

    running = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d leftover entries, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
